// File: rtl/ringosc_meas_pkg.sv
// Shared types and constants for the ring-oscillator frequency counter.
package ringosc_meas_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } meas_state_e;

  // Cycles spent flushing the synchroniser and edge register after a tap switch
  localparam int unsigned ARM_CYCLES  = 3;
  localparam int unsigned SYNC_STAGES = 2;

  localparam int unsigned GATE_LOG2_W = 5;
  localparam int unsigned RD_RES_W    = 24;

  // Readout byte selects
  localparam logic [1:0] BSEL_B0     = 2'd0;
  localparam logic [1:0] BSEL_B1     = 2'd1;
  localparam logic [1:0] BSEL_B2     = 2'd2;
  localparam logic [1:0] BSEL_STATUS = 2'd3;

  // Status byte bit positions
  localparam int unsigned STAT_VALID = 7;
  localparam int unsigned STAT_BUSY  = 6;
  localparam int unsigned STAT_OVF   = 5;

  // Limit a requested gate exponent to the largest supported one
  function automatic logic [GATE_LOG2_W-1:0] clamp_gate_log2(
    input logic [GATE_LOG2_W-1:0] g,
    input int unsigned            max_log2
  );
    if (32'(g) > max_log2) return GATE_LOG2_W'(max_log2);
    return g;
  endfunction

endpackage

// File: rtl/ringosc_freq_counter_if.sv
// Control/readout bus of the ring-oscillator frequency counter.
interface ringosc_freq_counter_if
  import ringosc_meas_pkg::*;
#(
  parameter int unsigned NUM_TAPS = 8
) ();

  logic [$clog2(NUM_TAPS)-1:0] tap_sel;
  logic [GATE_LOG2_W-1:0]      gate_log2;
  logic                        start;
  logic [1:0]                  byte_sel;
  logic                        busy;
  logic                        valid;
  logic                        ovf;
  logic [7:0]                  rd_data;

  modport master (
    output tap_sel, gate_log2, start, byte_sel,
    input  busy, valid, ovf, rd_data
  );

  modport slave (
    input  tap_sel, gate_log2, start, byte_sel,
    output busy, valid, ovf, rd_data
  );

endinterface

// File: rtl/ringosc_sync_edge.sv
// Multi-flop synchroniser for an asynchronous tap plus rising-edge detect.
module ringosc_sync_edge
  import ringosc_meas_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              q_d;

  // Shift the asynchronous level through the synchroniser, keep last synced value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      q_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      q_d    <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~q_d;

endmodule

// File: rtl/ringosc_freq_counter.sv
// Ring-oscillator tap frequency counter: tap mux, gated edge counter, byte readout.
module ringosc_freq_counter
  import ringosc_meas_pkg::*;
#(
  parameter int unsigned NUM_TAPS      = 8,
  parameter int unsigned CNT_W         = 24,
  parameter int unsigned GATE_LOG2_MAX = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_TAPS-1:0] tap_in,
  ringosc_freq_counter_if.slave bus
);

  localparam int unsigned SEL_W  = $clog2(NUM_TAPS);
  localparam int unsigned GCNT_W = GATE_LOG2_MAX + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  meas_state_e            state_q, state_d;
  logic [SEL_W-1:0]       sel_q;
  logic [GATE_LOG2_W-1:0] glog_q;
  logic [GCNT_W-1:0]      gate_q;
  logic [GCNT_W-1:0]      gate_len_m1;
  logic                   gate_zero;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       result_q;
  logic                   valid_q;
  logic                   ovf_q;

  logic                   busy;
  logic                   accept;
  logic                   arm_last;
  logic                   count_en;
  logic                   finish;

  logic                   tap_mux;
  logic                   rise;

  logic [RD_RES_W-1:0]    res_ext;
  logic [7:0]             status;
  logic [7:0]             rd_data;

  assign tap_mux     = tap_in[sel_q];
  assign gate_zero   = (gate_q == '0);
  assign gate_len_m1 = (GCNT_W'(1) << glog_q) - GCNT_W'(1);

  ringosc_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (tap_mux),
    .rise  (rise)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state: ARM and COUNT both end when the shared gate counter hits zero
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = ARM;
      ARM:     if (gate_zero) state_d = COUNT;
      COUNT:   if (gate_zero) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: per-state control strobes for the datapath
  always_comb begin
    busy     = 1'b0;
    accept   = 1'b0;
    arm_last = 1'b0;
    count_en = 1'b0;
    finish   = 1'b0;
    unique case (state_q)
      IDLE:  accept = bus.start;
      ARM: begin
        busy     = 1'b1;
        arm_last = gate_zero;
      end
      COUNT: begin
        busy     = 1'b1;
        count_en = 1'b1;
      end
      DONE: begin
        busy   = 1'b1;
        finish = 1'b1;
      end
      default: ;
    endcase
  end

  // Capture tap select and clamped gate exponent on an accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= '0;
      glog_q <= '0;
    end else if (accept) begin
      sel_q  <= bus.tap_sel;
      glog_q <= clamp_gate_log2(bus.gate_log2, GATE_LOG2_MAX);
    end
  end

  // Gate down-counter: times the ARM flush first, then is reloaded for the COUNT window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_q <= '0;
    end else if (accept) begin
      gate_q <= GCNT_W'(ARM_CYCLES - 1);
    end else if (arm_last) begin
      gate_q <= gate_len_m1;
    end else if (busy && !gate_zero) begin
      gate_q <= gate_q - GCNT_W'(1);
    end
  end

  // Saturating edge counter with sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (count_en && rise) begin
      if (cnt_q == CNT_MAX) ovf_q <= 1'b1;
      else                  cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Result register and valid flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      valid_q  <= 1'b0;
    end else if (accept) begin
      valid_q  <= 1'b0;
    end else if (finish) begin
      result_q <= cnt_q;
      valid_q  <= 1'b1;
    end
  end

  // Readout mux over the zero-extended result and status byte
  always_comb begin
    res_ext            = RD_RES_W'(result_q);
    status             = '0;
    status[STAT_VALID] = valid_q;
    status[STAT_BUSY]  = busy;
    status[STAT_OVF]   = ovf_q;
    unique case (bus.byte_sel)
      BSEL_B0:     rd_data = res_ext[7:0];
      BSEL_B1:     rd_data = res_ext[15:8];
      BSEL_B2:     rd_data = res_ext[23:16];
      BSEL_STATUS: rd_data = status;
      default:     rd_data = status;
    endcase
  end

  assign bus.busy    = busy;
  assign bus.valid   = valid_q;
  assign bus.ovf     = ovf_q;
  assign bus.rd_data = rd_data;

endmodule

// File: tb/tb_ringosc_freq_counter.sv
// Self-checking bench for ringosc_freq_counter: three instances (default, CNT_W=8,
// GATE_LOG2_MAX=4) driven by periodic or constant tap generators.
module tb_ringosc_freq_counter;

  localparam int NDUT = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Tap generators: period 0 means constant level lvl
  int         per   [NDUT][8] = '{default: 0};
  logic       lvl   [NDUT][8] = '{default: 1'b0};
  int         ph    [NDUT][8] = '{default: 0};
  logic [7:0] tap_v [NDUT]    = '{default: 8'h00};

  logic       start_v [NDUT] = '{default: 1'b0};
  logic [2:0] sel_v   [NDUT] = '{default: 3'd0};
  logic [4:0] glog_v  [NDUT] = '{default: 5'd0};
  logic [1:0] bsel_v  [NDUT] = '{default: 2'd0};
  logic       busy_v  [NDUT];
  logic       valid_v [NDUT];
  logic       ovf_v   [NDUT];
  logic [7:0] rd_v    [NDUT];

  int   vrise [NDUT] = '{default: 0};
  logic vprev [NDUT] = '{default: 1'b0};

  ringosc_freq_counter_if #(.NUM_TAPS(8)) if_a ();
  ringosc_freq_counter_if #(.NUM_TAPS(8)) if_s ();
  ringosc_freq_counter_if #(.NUM_TAPS(8)) if_c ();

  assign if_a.start = start_v[0]; assign if_a.tap_sel = sel_v[0];
  assign if_a.gate_log2 = glog_v[0]; assign if_a.byte_sel = bsel_v[0];
  assign if_s.start = start_v[1]; assign if_s.tap_sel = sel_v[1];
  assign if_s.gate_log2 = glog_v[1]; assign if_s.byte_sel = bsel_v[1];
  assign if_c.start = start_v[2]; assign if_c.tap_sel = sel_v[2];
  assign if_c.gate_log2 = glog_v[2]; assign if_c.byte_sel = bsel_v[2];

  assign busy_v[0] = if_a.busy; assign valid_v[0] = if_a.valid;
  assign ovf_v[0]  = if_a.ovf;  assign rd_v[0]    = if_a.rd_data;
  assign busy_v[1] = if_s.busy; assign valid_v[1] = if_s.valid;
  assign ovf_v[1]  = if_s.ovf;  assign rd_v[1]    = if_s.rd_data;
  assign busy_v[2] = if_c.busy; assign valid_v[2] = if_c.valid;
  assign ovf_v[2]  = if_c.ovf;  assign rd_v[2]    = if_c.rd_data;

  ringosc_freq_counter #(.NUM_TAPS(8), .CNT_W(24), .GATE_LOG2_MAX(20)) dut_a (
    .clk(clk), .rst_n(rst_n), .tap_in(tap_v[0]), .bus(if_a.slave));
  ringosc_freq_counter #(.NUM_TAPS(8), .CNT_W(8), .GATE_LOG2_MAX(20)) dut_s (
    .clk(clk), .rst_n(rst_n), .tap_in(tap_v[1]), .bus(if_s.slave));
  ringosc_freq_counter #(.NUM_TAPS(8), .CNT_W(24), .GATE_LOG2_MAX(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .tap_in(tap_v[2]), .bus(if_c.slave));

  // Tap waveforms change on the falling edge, one rising edge per period
  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      for (int i = 0; i < 8; i++) begin
        if (per[d][i] == 0) begin
          ph[d][i]    <= 0;
          tap_v[d][i] <= lvl[d][i];
        end else begin
          ph[d][i]    <= (ph[d][i] + 1 >= per[d][i]) ? 0 : ph[d][i] + 1;
          tap_v[d][i] <= (ph[d][i] < per[d][i] / 2);
        end
      end
    end
  end

  // Count rising edges of valid per instance
  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (valid_v[d] === 1'b1 && vprev[d] !== 1'b1) vrise[d] <= vrise[d] + 1;
      vprev[d] <= valid_v[d];
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  task automatic read_back(input int d, output logic [23:0] res, output logic [7:0] st);
    bsel_v[d] = 2'd0; #1 res[7:0]   = rd_v[d];
    bsel_v[d] = 2'd1; #1 res[15:8]  = rd_v[d];
    bsel_v[d] = 2'd2; #1 res[23:16] = rd_v[d];
    bsel_v[d] = 2'd3; #1 st         = rd_v[d];
  endtask

  // Pulse start and count falling edges with busy high, bounded
  task automatic run_meas(input int d, input logic [2:0] sel, input logic [4:0] g,
                          output int cyc, output bit timed_out);
    @(negedge clk);
    sel_v[d] = sel; glog_v[d] = g; start_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
    cyc = 0;
    while (busy_v[d] === 1'b1 && cyc < 4000) begin
      cyc++;
      @(negedge clk);
    end
    timed_out = (busy_v[d] !== 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      for (int b = 0; b < 4; b++) begin
        bsel_v[d] = 2'(b);
        #1;
        compared++;
        if (rd_v[d] !== 8'h00) begin
          mismatched++;
          $display("FAIL reset_rd dut%0d byte_sel=%0d: got %h, want 00", d, b, rd_v[d]);
        end
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      compared++;
      if (busy_v[d] !== 1'b0 || valid_v[d] !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_release dut%0d: busy=%b valid=%b, want 0 0", d, busy_v[d], valid_v[d]);
      end
    end
  endtask

  task automatic test_basic();
    int cyc; bit to; logic [23:0] res; logic [7:0] st;
    for (int i = 0; i < 8; i++) per[0][i] = 2 * int'($urandom_range(2, 20));
    per[0][3] = 10;
    repeat (50) @(negedge clk);
    run_meas(0, 3'd3, 5'd10, cyc, to);
    compared++;
    if (to || cyc != 1028) begin
      mismatched++;
      $display("FAIL basic_busy_len: got %0d cycles (timeout=%0b), want 1028", cyc, to);
    end
    compared++;
    if (valid_v[0] !== 1'b1 || ovf_v[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL basic_flags: valid=%b ovf=%b, want 1 0", valid_v[0], ovf_v[0]);
    end
    read_back(0, res, st);
    compared++;
    if (res !== 24'd102 && res !== 24'd103) begin
      mismatched++;
      $display("FAIL basic_count: got %0d, want 102 or 103", res);
    end
    compared++;
    if (st !== 8'h80) begin
      mismatched++;
      $display("FAIL basic_status: got %h, want 80", st);
    end
  endtask

  task automatic test_saturation();
    int cyc; bit to; logic [23:0] res; logic [7:0] st;
    per[1][2] = 4;
    repeat (50) @(negedge clk);
    run_meas(1, 3'd2, 5'd10, cyc, to);
    compared++;
    if (to || cyc != 1028) begin
      mismatched++;
      $display("FAIL sat_busy_len: got %0d cycles (timeout=%0b), want 1028", cyc, to);
    end
    read_back(1, res, st);
    compared++;
    if (res !== 24'h0000FF) begin
      mismatched++;
      $display("FAIL sat_result: got %h, want 0000ff", res);
    end
    compared++;
    if (st !== 8'hA0 || ovf_v[1] !== 1'b1) begin
      mismatched++;
      $display("FAIL sat_status: got %h ovf=%b, want a0 ovf=1", st, ovf_v[1]);
    end
  endtask

  task automatic test_clamp();
    int cyc; bit to; logic [23:0] res; logic [7:0] st;
    for (int i = 0; i < 8; i++) begin
      per[2][i] = 0;
      lvl[2][i] = 1'($urandom_range(0, 1));
    end
    lvl[2][0] = 1'b0;
    lvl[2][1] = 1'b1;
    repeat (5) @(negedge clk);
    run_meas(2, 3'd0, 5'd0, cyc, to);
    compared++;
    if (to || cyc != 5) begin
      mismatched++;
      $display("FAIL clamp_g0_len: got %0d cycles, want 5", cyc);
    end
    run_meas(2, 3'd1, 5'd31, cyc, to);
    compared++;
    if (to || cyc != 20) begin
      mismatched++;
      $display("FAIL clamp_len: got %0d cycles, want 20", cyc);
    end
    read_back(2, res, st);
    compared++;
    if (res !== 24'd0 || st !== 8'h80) begin
      mismatched++;
      $display("FAIL clamp_result: got res=%0d st=%h, want 0 80", res, st);
    end
    run_meas(2, 3'd1, 5'd3, cyc, to);
    compared++;
    if (to || cyc != 12) begin
      mismatched++;
      $display("FAIL clamp_unclamped_len: got %0d cycles, want 12", cyc);
    end
  endtask

  task automatic test_start_busy();
    int cyc; int base; logic [23:0] res; logic [7:0] st;
    per[0][3] = 10;
    per[0][5] = 4;
    repeat (50) @(negedge clk);
    base = vrise[0];
    @(negedge clk);
    sel_v[0] = 3'd3; glog_v[0] = 5'd10; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    cyc = 0;
    while (busy_v[0] === 1'b1 && cyc < 4000) begin
      if (cyc == 500) begin start_v[0] = 1'b1; sel_v[0] = 3'd5; glog_v[0] = 5'd2; end
      if (cyc == 503) start_v[0] = 1'b0;
      cyc++;
      @(negedge clk);
    end
    start_v[0] = 1'b0;
    compared++;
    if (cyc != 1028) begin
      mismatched++;
      $display("FAIL busy_restart_len: got %0d cycles, want 1028", cyc);
    end
    read_back(0, res, st);
    compared++;
    if (res !== 24'd102 && res !== 24'd103) begin
      mismatched++;
      $display("FAIL busy_restart_count: got %0d, want 102 or 103", res);
    end
    @(negedge clk);
    #2;
    compared++;
    if (vrise[0] - base != 1 || busy_v[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL busy_restart_vrise: got %0d rises busy=%b, want 1 rise busy=0",
               vrise[0] - base, busy_v[0]);
    end
  endtask

  task automatic test_start_in_done();
    @(negedge clk);
    sel_v[0] = 3'd3; glog_v[0] = 5'd0; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    compared++;
    if (busy_v[0] !== 1'b1 || valid_v[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL done_phase: busy=%b valid=%b, want 1 0", busy_v[0], valid_v[0]);
    end
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    compared++;
    if (busy_v[0] !== 1'b0 || valid_v[0] !== 1'b1) begin
      mismatched++;
      $display("FAIL done_start_after: busy=%b valid=%b, want 0 1", busy_v[0], valid_v[0]);
    end
    repeat (2) @(negedge clk);
    compared++;
    if (busy_v[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL done_start_ignored: busy=%b, want 0", busy_v[0]);
    end
  endtask

  task automatic test_back_to_back();
    int lows = 0; int vlows = 0;
    @(negedge clk);
    sel_v[0] = 3'd3; glog_v[0] = 5'd0; start_v[0] = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (busy_v[0] === 1'b0) begin
        lows++;
        if (valid_v[0] === 1'b1) vlows++;
      end
    end
    start_v[0] = 1'b0;
    compared++;
    if (lows != 4 || vlows != 4) begin
      mismatched++;
      $display("FAIL b2b_retrigger: got %0d idle cycles (%0d valid), want 4 (4)", lows, vlows);
    end
    @(negedge clk);
    compared++;
    if (busy_v[0] !== 1'b0 || valid_v[0] !== 1'b1) begin
      mismatched++;
      $display("FAIL b2b_stop: busy=%b valid=%b, want 0 1", busy_v[0], valid_v[0]);
    end
  endtask

  task automatic test_reset_mid();
    int cyc; bit to; logic [23:0] res; logic [7:0] st;
    @(negedge clk);
    sel_v[0] = 3'd3; glog_v[0] = 5'd10; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (520) @(negedge clk);
    compared++;
    if (busy_v[0] !== 1'b1) begin
      mismatched++;
      $display("FAIL midrst_pre: busy=%b, want 1", busy_v[0]);
    end
    rst_n = 1'b0;
    #1;
    compared++;
    if (busy_v[0] !== 1'b0 || valid_v[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL midrst_flags: busy=%b valid=%b, want 0 0", busy_v[0], valid_v[0]);
    end
    read_back(0, res, st);
    compared++;
    if (res !== 24'd0 || st !== 8'h00) begin
      mismatched++;
      $display("FAIL midrst_rd: got res=%h st=%h, want 000000 00", res, st);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_meas(0, 3'd3, 5'd8, cyc, to);
    compared++;
    if (to || cyc != 260) begin
      mismatched++;
      $display("FAIL midrst_next_len: got %0d cycles, want 260", cyc);
    end
    read_back(0, res, st);
    compared++;
    if ((res !== 24'd25 && res !== 24'd26) || st !== 8'h80) begin
      mismatched++;
      $display("FAIL midrst_next_count: got res=%0d st=%h, want 25..26 80", res, st);
    end
  endtask

  task automatic test_random();
    int cyc; bit to; logic [23:0] res; logic [7:0] st;
    int n, p, lo, hi;
    logic [2:0] sel; logic [4:0] g;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          per[0][i] = 0;
          lvl[0][i] = 1'($urandom_range(0, 1));
        end else begin
          per[0][i] = 2 * int'($urandom_range(2, 20));
        end
      end
      sel = 3'($urandom_range(0, 7));
      g   = 5'($urandom_range(0, 9));
      repeat (50) @(negedge clk);
      run_meas(0, sel, g, cyc, to);
      n = 1 << g;
      p = per[0][sel];
      lo = (p == 0) ? 0 : n / p;
      hi = (p == 0) ? 0 : (n + p - 1) / p;
      compared++;
      if (to || cyc != n + 4) begin
        mismatched++;
        $display("FAIL rand%0d_len: g=%0d got %0d cycles, want %0d", it, g, cyc, n + 4);
      end
      read_back(0, res, st);
      compared++;
      if (int'(res) < lo || int'(res) > hi || st !== 8'h80) begin
        mismatched++;
        $display("FAIL rand%0d_count: tap=%0d per=%0d g=%0d got %0d st=%h, want %0d..%0d st=80",
                 it, sel, p, g, res, st, lo, hi);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_clamp();
    test_start_busy();
    test_start_in_done();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
